// File: rtl/self_test_sequencer_if.sv
// Signal bundle between the self-test sequencer and its surroundings.
// The master modport belongs to the sequencer; the slave modport is used
// by whatever drives the word stream and consumes the strobes.
//
// Handshake: word_vld qualifies word_in for exactly one cycle. There is
// no ready/backpressure path. A word is accepted only when st_load is high
// in the same cycle (LOAD state); words offered in any other state are
// dropped. All strobe outputs are one-cycle pulses.
interface self_test_sequencer_if;
    logic        f_layer;
    logic [31:0] word_in;
    logic        word_vld;
    logic        sort_finish;
    logic        st_load;
    logic        st_start;
    logic        tx_out;
    logic        tx_hdr;
    logic        busy;
    logic        err_timeout;
    logic [2:0]  state_dbg;

    modport master (
        input  f_layer, word_in, word_vld, sort_finish,
        output st_load, st_start, tx_out, tx_hdr, busy, err_timeout, state_dbg
    );

    modport slave (
        output f_layer, word_in, word_vld, sort_finish,
        input  st_load, st_start, tx_out, tx_hdr, busy, err_timeout, state_dbg
    );
endinterface

// File: rtl/self_test_sequencer.sv
// Frame sequencer for a sort self-test: hunts a sync word, loads a fixed
// payload into the self-test, starts it, waits (bounded) for completion,
// then paces out a header strobe and one strobe per payload word.
module self_test_sequencer #(
    parameter logic [31:0] SYNC_WORD     = 32'hA5C3_3C5A,
    parameter int          PAYLOAD_WORDS = 8,
    parameter int          WORD_PACE     = 4,
    parameter int          TIMEOUT       = 1024
) (
    input  logic                  div_8_clk,
    input  logic                  rst,
    self_test_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HUNT    = 3'd1,
        S_LOAD    = 3'd2,
        S_RUN     = 3'd3,
        S_TX_HDR  = 3'd4,
        S_TX_DATA = 3'd5,
        S_GAP     = 3'd6
    } state_t;

    // Terminal counts; counters only ever return to zero by explicit clear.
    localparam logic [7:0]  WORD_LAST = 8'(PAYLOAD_WORDS - 1);
    localparam logic [3:0]  PACE_LAST = 4'(WORD_PACE - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [3:0]  pace_cnt_q, pace_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
    logic        st_start_q, st_start_d;

    logic        load_strobe;
    logic        tx_strobe;
    logic        hdr_strobe;

    // State and counter registers; reset aborts any frame immediately.
    always_ff @(posedge div_8_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            pace_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            st_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pace_cnt_q <= pace_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            st_start_q <= st_start_d;
        end
    end

    // Next-state, counter updates and per-state strobes.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        pace_cnt_d  = pace_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
        load_strobe = 1'b0;
        tx_strobe   = 1'b0;
        hdr_strobe  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Single-cycle decision point; f_layer is looked at only here.
                word_cnt_d = '0;
                pace_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = bus.f_layer ? S_RUN : S_HUNT;
            end

            S_HUNT: begin
                if (bus.word_vld && (bus.word_in == SYNC_WORD)) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
                end
            end

            S_LOAD: begin
                // Every valid word here is payload, even one equal to the sync word.
                load_strobe = bus.word_vld;
                if (bus.word_vld) begin
                    if (word_cnt_q == WORD_LAST) begin
                        state_d    = S_RUN;
                        word_cnt_d = '0;
                        tmo_cnt_d  = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end
            end

            S_RUN: begin
                // Completion takes priority over the timeout expiring in the same cycle.
                if (bus.sort_finish) begin
                    state_d    = S_TX_HDR;
                    pace_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_HUNT;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end

            S_TX_HDR: begin
                tx_strobe  = (pace_cnt_q == 4'd0);
                hdr_strobe = (pace_cnt_q == 4'd0);
                if (pace_cnt_q == PACE_LAST) begin
                    state_d    = S_TX_DATA;
                    pace_cnt_d = '0;
                    word_cnt_d = '0;
                end else begin
                    pace_cnt_d = pace_cnt_q + 4'd1;
                end
            end

            S_TX_DATA: begin
                // One strobe at the start of each pace window, one window per word.
                tx_strobe = (pace_cnt_q == 4'd0);
                if (pace_cnt_q == PACE_LAST) begin
                    pace_cnt_d = '0;
                    if (word_cnt_q == WORD_LAST) begin
                        state_d    = S_GAP;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end else begin
                    pace_cnt_d = pace_cnt_q + 4'd1;
                end
            end

            S_GAP: begin
                if (pace_cnt_q == PACE_LAST) begin
                    state_d    = S_IDLE;
                    pace_cnt_d = '0;
                end else begin
                    pace_cnt_d = pace_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Start pulse is registered so it lines up with the first RUN cycle on every entry.
    always_comb begin
        st_start_d = (state_d == S_RUN) && (state_q != S_RUN);
    end

    assign bus.st_load     = load_strobe;
    assign bus.st_start    = st_start_q;
    assign bus.tx_out      = tx_strobe;
    assign bus.tx_hdr      = hdr_strobe;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HUNT);
    assign bus.err_timeout = err_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_self_test_sequencer.sv
// Directed bench for self_test_sequencer. Main instance uses default
// parameters; a second instance with TIMEOUT=16 covers the timeout paths.
module tb_self_test_sequencer;

    localparam logic [31:0] SYNC = 32'hA5C3_3C5A;
    localparam int PW = 8;
    localparam int WP = 4;

    logic div_8_clk = 1'b0;
    logic rst;

    always #5 div_8_clk = ~div_8_clk;

    self_test_sequencer_if bus();
    self_test_sequencer_if bus16();

    self_test_sequencer #(
        .SYNC_WORD(SYNC), .PAYLOAD_WORDS(PW), .WORD_PACE(WP), .TIMEOUT(1024)
    ) u_dut (
        .div_8_clk(div_8_clk), .rst(rst), .bus(bus)
    );

    self_test_sequencer #(
        .SYNC_WORD(SYNC), .PAYLOAD_WORDS(PW), .WORD_PACE(WP), .TIMEOUT(16)
    ) u_dut16 (
        .div_8_clk(div_8_clk), .rst(rst), .bus(bus16)
    );

    int n_pass   = 0;
    int n_checks = 0;
    int cyc_n    = 0;

    // Per-cycle snapshots (main instance: o_*, TIMEOUT=16 instance: p_*)
    logic [31:0] o_state, o_load, o_start, o_tx, o_hdr, o_busy, o_err, o_outs;
    logic [31:0] p_state, p_start, p_tx, p_err;

    // Event accumulators for the main instance
    int n_load, n_start, n_hdr, n_txd, bad_space, last_tx, p_ntx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clr_counts();
        n_load = 0; n_start = 0; n_hdr = 0; n_txd = 0;
        bad_space = 0; last_tx = -1; p_ntx = 0;
    endtask

    // Inputs are set at the negedge before calling; sample 1ns later, then move to next negedge.
    task automatic cyc();
        #1;
        cyc_n++;
        o_state = 32'(bus.state_dbg);
        o_load  = 32'(bus.st_load);
        o_start = 32'(bus.st_start);
        o_tx    = 32'(bus.tx_out);
        o_hdr   = 32'(bus.tx_hdr);
        o_busy  = 32'(bus.busy);
        o_err   = 32'(bus.err_timeout);
        o_outs  = 32'({bus.st_load, bus.st_start, bus.tx_out, bus.tx_hdr, bus.busy, bus.err_timeout});
        if (bus.st_load)  n_load++;
        if (bus.st_start) n_start++;
        if (bus.tx_out) begin
            if (bus.tx_hdr) n_hdr++;
            else            n_txd++;
            if (last_tx >= 0 && (cyc_n - last_tx) != WP) bad_space++;
            last_tx = cyc_n;
        end
        p_state = 32'(bus16.state_dbg);
        p_start = 32'(bus16.st_start);
        p_tx    = 32'(bus16.tx_out);
        p_err   = 32'(bus16.err_timeout);
        if (bus16.tx_out) p_ntx++;
        @(negedge div_8_clk);
    endtask

    task automatic run_until(input bit sel16, input logic [31:0] st, input int bound, input string tag);
        logic [31:0] done;
        done = 0;
        for (int i = 0; i < bound && done == 0; i++) begin
            cyc();
            if ((sel16 ? p_state : o_state) == st) done = 1;
        end
        chk(tag, done, 1);
    endtask

    // Sync word then PW payload words into the TIMEOUT=16 instance.
    task automatic feed16();
        bus16.word_vld = 1'b1;
        bus16.word_in  = SYNC;
        cyc();
        for (int i = 0; i < PW; i++) begin
            bus16.word_in = 32'h0000_0100 + 32'(i);
            cyc();
        end
        bus16.word_vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        bus.f_layer = 1'b1; bus.word_in = '0; bus.word_vld = 1'b0; bus.sort_finish = 1'b0;
        bus16.f_layer = 1'b0; bus16.word_in = '0; bus16.word_vld = 1'b0; bus16.sort_finish = 1'b0;
        clr_counts();
        @(negedge div_8_clk);
        @(negedge div_8_clk);

        // Reset state
        cyc();
        chk("rst_state", o_state, 0);
        chk("rst_outputs", o_outs, 0);

        // f_layer=1: IDLE then RUN with st_start on cycle 2; sort_finish in st_start cycle accepted
        rst = 1'b0;
        clr_counts();
        cyc();
        chk("a_idle_first", o_state, 0);
        chk("a_idle_busy", o_busy, 0);
        chk("a_idle_nostart", o_start, 0);
        bus.sort_finish = 1'b1;
        cyc();
        chk("a_run_state", o_state, 3);
        chk("a_run_start", o_start, 1);
        bus.sort_finish = 1'b0;
        bus.f_layer = 1'b0;
        cyc();
        chk("a_txhdr_state", o_state, 4);
        chk("a_txhdr_strobe", o_tx & o_hdr, 1);
        run_until(1'b0, 6, 80, "a_reach_gap");
        t0 = cyc_n;
        run_until(1'b0, 0, 20, "a_reach_idle");
        chk("a_gap_len", 32'(cyc_n - t0), WP);
        chk("a_hdr_count", n_hdr, 1);
        chk("a_data_count", n_txd, PW);
        chk("a_no_load", n_load, 0);
        chk("a_start_count", n_start, 1);
        chk("a_spacing", bad_space, 0);

        // HUNT garbage, sync, payload with in-LOAD sync word, sort_finish 20 cycles after st_start
        clr_counts();
        bus.word_vld = 1'b1;
        bus.word_in = 32'h0000_0000;
        cyc();
        chk("b_hunt_zero_state", o_state, 1);
        chk("b_hunt_zero_load", o_load, 0);
        bus.word_in = 32'hFFFF_FFFF;
        cyc();
        chk("b_hunt_ones_state", o_state, 1);
        bus.word_in = SYNC;
        cyc();
        chk("b_hunt_sync_state", o_state, 1);
        chk("b_hunt_sync_load", o_load, 0);
        for (int i = 0; i < PW; i++) begin
            if (i == 4) begin
                bus.word_vld = 1'b0;
                cyc();
                chk("b_load_gap_state", o_state, 2);
                chk("b_load_gap_load", o_load, 0);
                bus.word_vld = 1'b1;
            end
            bus.word_in = (i == 2) ? SYNC : 32'h0000_1000 + 32'(i);
            cyc();
            chk("b_load_state", o_state, 2);
            chk("b_load_strobe", o_load, 1);
        end
        bus.word_vld = 1'b0;
        cyc();
        chk("b_run_state", o_state, 3);
        chk("b_run_start", o_start, 1);
        bus.word_vld = 1'b1;
        for (int i = 1; i < 20; i++) begin
            bus.word_in = $urandom;
            cyc();
        end
        chk("b_run_hold", o_state, 3);
        chk("b_run_ignores_words", n_load, PW);
        bus.word_vld = 1'b0;
        bus.sort_finish = 1'b1;
        cyc();
        chk("b_run_c20_state", o_state, 3);
        bus.sort_finish = 1'b0;
        cyc();
        chk("b_txhdr_state", o_state, 4);
        chk("b_txhdr_hdr", o_hdr, 1);
        bus.f_layer = 1'b1;
        run_until(1'b0, 0, 80, "b_reach_idle");
        chk("b_load_count", n_load, PW);
        chk("b_start_count", n_start, 1);
        chk("b_hdr_count", n_hdr, 1);
        chk("b_data_count", n_txd, PW);
        chk("b_spacing", bad_space, 0);
        chk("b_no_err", o_err, 0);

        // Reset during TX_DATA after 3 data strobes
        clr_counts();
        bus.sort_finish = 1'b1;
        cyc();
        chk("c_run_start", o_start, 1);
        bus.sort_finish = 1'b0;
        bus.f_layer = 1'b0;
        begin
            logic [31:0] got3;
            got3 = 0;
            for (int i = 0; i < 60 && got3 == 0; i++) begin
                cyc();
                if (n_txd == 3) got3 = 1;
            end
            chk("c_three_strobes", got3, 1);
        end
        cyc();
        chk("c_pre_rst_state", o_state, 5);
        rst = 1'b1;
        cyc();
        chk("c_rst_state", o_state, 0);
        chk("c_rst_outputs", o_outs, 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("c_release_idle", o_state, 0);
        bus.sort_finish = 1'b1;
        cyc();
        chk("c_hunt_after_idle", o_state, 1);
        cyc();
        chk("c_hunt_ignores_finish", o_state, 1);
        bus.sort_finish = 1'b0;
        chk("c_no_more_tx", n_txd, 3);
        chk("c_start_count", n_start, 1);

        // TIMEOUT=16 instance: coincident finish wins
        clr_counts();
        feed16();
        cyc();
        chk("d_run_start", p_start, 1);
        for (int i = 1; i < 15; i++) cyc();
        bus16.sort_finish = 1'b1;
        cyc();
        chk("d_run_c15_state", p_state, 3);
        bus16.sort_finish = 1'b0;
        cyc();
        chk("d_coinc_txhdr", p_state, 4);
        chk("d_coinc_tx", p_tx, 1);
        chk("d_coinc_no_err", p_err, 0);
        run_until(1'b1, 0, 80, "d_reach_idle");

        // No finish: 16 RUN cycles, then HUNT with sticky error, no strobes
        clr_counts();
        feed16();
        for (int i = 0; i < 16; i++) cyc();
        chk("e_run_last_state", p_state, 3);
        chk("e_run_last_err", p_err, 0);
        cyc();
        chk("e_timeout_hunt", p_state, 1);
        chk("e_timeout_err", p_err, 1);
        chk("e_no_tx", p_ntx, 0);

        // Error stays set and next frame still runs
        feed16();
        bus16.sort_finish = 1'b1;
        cyc();
        chk("f_run_state", p_state, 3);
        bus16.sort_finish = 1'b0;
        cyc();
        chk("f_txhdr_state", p_state, 4);
        chk("f_err_sticky", p_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
